// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Drives register enables/clears and counts frozen-PC cycles.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             md_start,
    input  logic             md_done,
    output logic             md_go,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             flush_mw,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_stall;
    assign mem_stall = mem_req & ~mem_ready;

    // State register; reset abandons any wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: only RUN looks at hazard inputs
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                end else if (md_start) begin
                    state_next = MD_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Mealy outputs: enables, clears, launch pulse, busy
    always_comb begin
        en_pc    = 1'b1;
        en_fd    = 1'b1;
        en_de    = 1'b1;
        en_em    = 1'b1;
        en_mw    = 1'b1;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        flush_em = 1'b0;
        flush_mw = 1'b0;
        md_go    = 1'b0;
        busy     = 1'b0;
        if (reset) begin
            en_pc    = 1'b0;
            en_fd    = 1'b0;
            en_de    = 1'b0;
            en_em    = 1'b0;
            en_mw    = 1'b0;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            flush_em = 1'b1;
            flush_mw = 1'b1;
        end else begin
            busy = (state != RUN);
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        en_pc    = 1'b0;
                        en_fd    = 1'b0;
                        en_de    = 1'b0;
                        en_em    = 1'b0;
                        flush_mw = 1'b1;
                    end else if (md_start) begin
                        md_go    = 1'b1;
                        en_pc    = 1'b0;
                        en_fd    = 1'b0;
                        en_de    = 1'b0;
                        flush_em = 1'b1;
                    end else if (branch_taken) begin
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                    end else if (load_use) begin
                        en_pc    = 1'b0;
                        en_fd    = 1'b0;
                        flush_de = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        en_pc    = 1'b0;
                        en_fd    = 1'b0;
                        en_de    = 1'b0;
                        en_em    = 1'b0;
                        flush_mw = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!md_done) begin
                        en_pc    = 1'b0;
                        en_fd    = 1'b0;
                        en_de    = 1'b0;
                        en_em    = 1'b0;
                        flush_em = 1'b1;
                    end
                end
                default: begin
                    en_pc = 1'b1;
                end
            endcase
        end
    end

    // Performance counter of cycles with a frozen PC; wraps freely
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!en_pc) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl, including a 4-bit counter
// instance for the wrap check.
module tb_pipeline_ctrl;

    logic clk;
    logic reset;
    logic load_use, branch_taken, mem_req, mem_ready, md_start, md_done;

    logic md_go, en_pc, en_fd, en_de, en_em, en_mw;
    logic flush_fd, flush_de, flush_em, flush_mw, busy;
    logic [31:0] stall_cycles;

    logic md_go4, en_pc4, en_fd4, en_de4, en_em4, en_mw4;
    logic flush_fd4, flush_de4, flush_em4, flush_mw4, busy4;
    logic [3:0] stall_cycles4;

    int tests;
    int fails;

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .load_use(load_use), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .md_start(md_start), .md_done(md_done),
        .md_go(md_go),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de),
        .en_em(en_em), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_de(flush_de),
        .flush_em(flush_em), .flush_mw(flush_mw),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .load_use(load_use), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .md_start(md_start), .md_done(md_done),
        .md_go(md_go4),
        .en_pc(en_pc4), .en_fd(en_fd4), .en_de(en_de4),
        .en_em(en_em4), .en_mw(en_mw4),
        .flush_fd(flush_fd4), .flush_de(flush_de4),
        .flush_em(flush_em4), .flush_mw(flush_mw4),
        .busy(busy4), .stall_cycles(stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // en: {pc,fd,de,em,mw}; fl: {fd,de,em,mw}
    task automatic chk_out(input string tag, input logic [4:0] en_e,
                           input logic [3:0] fl_e, input logic go_e,
                           input logic busy_e);
        chk({tag, ".en"}, {27'd0, en_pc, en_fd, en_de, en_em, en_mw},
            {27'd0, en_e});
        chk({tag, ".flush"}, {28'd0, flush_fd, flush_de, flush_em, flush_mw},
            {28'd0, fl_e});
        chk({tag, ".md_go"}, {31'd0, md_go}, {31'd0, go_e});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, busy_e});
        chk({tag, ".en4"}, {27'd0, en_pc4, en_fd4, en_de4, en_em4, en_mw4},
            {27'd0, en_e});
        chk({tag, ".go4"}, {31'd0, md_go4}, {31'd0, go_e});
    endtask

    task automatic drive(input logic lu, input logic bt, input logic mr,
                         input logic mrdy, input logic ms, input logic md);
        load_use     = lu;
        branch_taken = bt;
        mem_req      = mr;
        mem_ready    = mrdy;
        md_start     = ms;
        md_done      = md;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // reset forcing
        @(negedge clk); #1;
        chk_out("reset_force", 5'b00000, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_cnt", stall_cycles, 32'd0);

        // idle
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk_out("idle", 5'b11111, 4'b0000, 1'b0, 1'b0);
            @(negedge clk);
        end
        chk("idle_cnt", stall_cycles, 32'd0);

        // load-use bubble
        drive(1, 0, 0, 0, 0, 0);
        #1 chk_out("lu", 5'b00111, 4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("lu_after", 5'b11111, 4'b0000, 1'b0, 1'b0);
        chk("lu_cnt", stall_cycles, 32'd1);
        @(negedge clk);

        // branch beats load-use
        drive(1, 1, 0, 0, 0, 0);
        #1 chk_out("br_lu", 5'b11111, 4'b1100, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("br_cnt", stall_cycles, 32'd1);

        // 3-cycle memory wait
        drive(0, 0, 1, 0, 0, 0);
        #1 chk_out("mem1", 5'b00001, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk_out("mem2", 5'b00001, 4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        #1 chk_out("mem3", 5'b00001, 4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 0);
        #1 chk_out("mem_rel", 5'b11111, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("mem_after", 5'b11111, 4'b0000, 1'b0, 1'b0);
        chk("mem_cnt", stall_cycles, 32'd4);
        @(negedge clk);

        // stray md_done in RUN
        drive(0, 0, 0, 0, 0, 1);
        #1 chk_out("md_stray", 5'b11111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("md_stray_after", 5'b11111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);

        // memory stall outranks md_start
        drive(0, 0, 1, 0, 1, 0);
        #1 chk_out("mdm_a", 5'b00001, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 0, 1, 1, 1, 0);
        #1 chk_out("mdm_b", 5'b11111, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0);
        #1 chk_out("mdm_go", 5'b00011, 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 1, 0);
            #1 chk_out("md_wait", 5'b00001, 4'b0010, 1'b0, 1'b1);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1, 1);
        #1 chk_out("md_done", 5'b11111, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("md_after", 5'b11111, 4'b0000, 1'b0, 1'b0);
        chk("md_cnt", stall_cycles, 32'd9);
        chk("md_cnt4", {28'd0, stall_cycles4}, 32'd9);
        @(negedge clk);

        // reset in 2nd MD_WAIT cycle
        drive(0, 0, 0, 0, 1, 0);
        #1 chk_out("rst_go", 5'b00011, 4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk_out("rst_w1", 5'b00001, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_out("rst_w2", 5'b00000, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_out("rst_after", 5'b11111, 4'b0000, 1'b0, 1'b0);
        chk("rst_cnt", stall_cycles, 32'd0);
        chk("rst_cnt4", {28'd0, stall_cycles4}, 32'd0);

        // counter wrap on the 4-bit instance
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("wrap_cnt4", {28'd0, stall_cycles4}, 32'd1);
        chk("wrap_cnt32", stall_cycles, 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
